// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding memory access with alignment,
// legality and timeout checking, RISC-V sized/sign-extended data.
module load_store_unit #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load_en,
   input  logic              i_store_en,
   input  logic [2:0]        i_funct3,
   input  logic [XLEN-1:0]   i_rs1_val,
   input  logic [XLEN-1:0]   i_imm,
   input  logic [XLEN-1:0]   i_rs2_val,
   input  logic [4:0]        i_rd,
   output logic              o_busy,
   output logic              o_rd_we,
   output logic [4:0]        o_rd,
   output logic [XLEN-1:0]   o_rd_val,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [XLEN-1:0]   o_mem_addr,
   output logic [XLEN-1:0]   o_mem_wdata,
   output logic [XLEN/8-1:0] o_mem_wstrb,
   input  logic              i_mem_ack,
   input  logic [XLEN-1:0]   i_mem_rdata,
   output logic              o_misaligned,
   output logic              o_illegal,
   output logic              o_timeout
);

   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);
   localparam int CW   = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              ill_q, ill_d;
   logic              mis_q, mis_d;
   logic              tmo_q, tmo_d;
   logic              cap, ld_cap;

   logic [XLEN-1:0]   addr_q, wdata_q, rdval_q;
   logic [NB-1:0]     wstrb_q;
   logic [4:0]        rd_q;
   logic [2:0]        f3_q;
   logic [OFFW-1:0]   off_q;
   logic              we_q;

   logic [XLEN-1:0]   ea, addr_a, dmask, wdata_a;
   logic [XLEN-1:0]   ld_sh, ld_val;
   logic [NB-1:0]     smask, strb_a;
   logic [OFFW-1:0]   off;
   logic              any_en, illegal, misal, op_ok;

   assign ea     = i_rs1_val + i_imm;
   assign off    = ea[OFFW-1:0];
   assign addr_a = {ea[XLEN-1:OFFW], {OFFW{1'b0}}};
   assign any_en = i_load_en | i_store_en;

   assign illegal = (i_load_en & i_store_en)
                  | (i_funct3 == 3'b111)
                  | (i_store_en & (i_funct3 == 3'b110))
                  | ((XLEN == 32) &
                     ((i_funct3 == 3'b011) | (i_funct3 == 3'b110)));

   always_comb begin
      misal = 1'b0;
      dmask = '0;
      smask = '0;
      case (i_funct3[1:0])
         2'b00: begin
            dmask = XLEN'(64'hFF);
            smask = NB'(8'h01);
         end
         2'b01: begin
            misal = ea[0];
            dmask = XLEN'(64'hFFFF);
            smask = NB'(8'h03);
         end
         2'b10: begin
            misal = |ea[1:0];
            dmask = XLEN'(64'hFFFF_FFFF);
            smask = NB'(8'h0F);
         end
         default: begin
            misal = |ea[2:0];
            dmask = '1;
            smask = '1;
         end
      endcase
   end

   assign op_ok   = any_en & ~illegal & ~misal;
   assign wdata_a = (i_rs2_val & dmask) << {off, 3'b000};
   assign strb_a  = smask << off;

   // Field extraction at the lane captured with the request
   assign ld_sh = i_mem_rdata >> {off_q, 3'b000};

   always_comb begin
      ld_val = '0;
      case (f3_q)
         3'b000:  ld_val = XLEN'($signed(ld_sh[7:0]));
         3'b001:  ld_val = XLEN'($signed(ld_sh[15:0]));
         3'b010:  ld_val = XLEN'($signed(ld_sh[31:0]));
         3'b011:  ld_val = ld_sh;
         3'b100:  ld_val = XLEN'(ld_sh[7:0]);
         3'b101:  ld_val = XLEN'(ld_sh[15:0]);
         3'b110:  ld_val = XLEN'(ld_sh[31:0]);
         default: ld_val = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ill_d   = 1'b0;
      mis_d   = 1'b0;
      tmo_d   = 1'b0;
      cap     = 1'b0;
      ld_cap  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (any_en) begin
               if (illegal) begin
                  ill_d = 1'b1;
               end else if (misal) begin
                  mis_d = 1'b1;
               end else begin
                  cap     = 1'b1;
                  cnt_d   = '0;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // Ack takes priority over an expiring timeout
            if (i_mem_ack) begin
               cnt_d   = '0;
               ld_cap  = ~we_q;
               state_d = we_q ? S_IDLE : S_DONE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               cnt_d   = '0;
               tmo_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ill_q   <= 1'b0;
         mis_q   <= 1'b0;
         tmo_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rd_q    <= '0;
         f3_q    <= '0;
         off_q   <= '0;
         we_q    <= 1'b0;
         rdval_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ill_q   <= ill_d;
         mis_q   <= mis_d;
         tmo_q   <= tmo_d;
         if (cap) begin
            addr_q  <= addr_a;
            wdata_q <= i_store_en ? wdata_a : '0;
            wstrb_q <= i_store_en ? strb_a : '0;
            rd_q    <= i_rd;
            f3_q    <= i_funct3;
            off_q   <= off;
            we_q    <= i_store_en;
         end
         if (ld_cap) begin
            rdval_q <= ld_val;
         end
      end
   end

   assign o_busy = i_rst &
                   ((state_q != S_IDLE) | op_ok);

   assign o_mem_req   = (state_q == S_WAIT);
   assign o_mem_we    = o_mem_req & we_q;
   assign o_mem_addr  = o_mem_req ? addr_q : '0;
   assign o_mem_wdata = o_mem_req ? wdata_q : '0;
   assign o_mem_wstrb = o_mem_req ? wstrb_q : '0;

   assign o_rd_we  = (state_q == S_DONE) & (rd_q != 5'd0);
   assign o_rd     = (state_q == S_DONE) ? rd_q : 5'd0;
   assign o_rd_val = (state_q == S_DONE) ? rdval_q : '0;

   assign o_misaligned = ill_q ? 1'b0 : mis_q;
   assign o_illegal    = ill_q;
   assign o_timeout    = tmo_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit (XLEN=32, TIMEOUT=8): directed spec cases
// followed by random accesses checked against a byte-level model.
module tb_load_store_unit;

   localparam int TMO = 8;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_load_en, i_store_en;
   logic [2:0]  i_funct3;
   logic [31:0] i_rs1_val, i_imm, i_rs2_val;
   logic [4:0]  i_rd;
   logic        o_busy, o_rd_we;
   logic [4:0]  o_rd;
   logic [31:0] o_rd_val;
   logic        o_mem_req, o_mem_we;
   logic [31:0] o_mem_addr, o_mem_wdata;
   logic [3:0]  o_mem_wstrb;
   logic        i_mem_ack;
   logic [31:0] i_mem_rdata;
   logic        o_misaligned, o_illegal, o_timeout;

   int checks   = 0;
   int failures = 0;

   load_store_unit #(.XLEN(32), .TIMEOUT(TMO)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_load_en    (i_load_en),
      .i_store_en   (i_store_en),
      .i_funct3     (i_funct3),
      .i_rs1_val    (i_rs1_val),
      .i_imm        (i_imm),
      .i_rs2_val    (i_rs2_val),
      .i_rd         (i_rd),
      .o_busy       (o_busy),
      .o_rd_we      (o_rd_we),
      .o_rd         (o_rd),
      .o_rd_val     (o_rd_val),
      .o_mem_req    (o_mem_req),
      .o_mem_we     (o_mem_we),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wdata  (o_mem_wdata),
      .o_mem_wstrb  (o_mem_wstrb),
      .i_mem_ack    (i_mem_ack),
      .i_mem_rdata  (i_mem_rdata),
      .o_misaligned (o_misaligned),
      .o_illegal    (o_illegal),
      .o_timeout    (o_timeout)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #400000;
      $display("FAIL watchdog observed=hang expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      i_load_en  = 1'b0;
      i_store_en = 1'b0;
      i_funct3   = 3'($urandom);
      i_rs1_val  = $urandom;
      i_imm      = $urandom;
      i_rs2_val  = $urandom;
      i_rd       = 5'($urandom);
   endtask

   task automatic garbage_inputs();
      i_load_en  = 1'($urandom);
      i_store_en = 1'($urandom);
      i_funct3   = 3'($urandom);
      i_rs1_val  = $urandom;
      i_imm      = $urandom;
      i_rs2_val  = $urandom;
      i_rd       = 5'($urandom);
   endtask

   // kind: 0 = legal access, 1 = illegal, 2 = misaligned
   function automatic void model(
      input bit ld, input bit st, input logic [2:0] f3,
      input logic [31:0] rs1, input logic [31:0] imm,
      input logic [31:0] rs2, input logic [31:0] rdata,
      output int kind, output logic [31:0] addr,
      output logic [31:0] wdata, output logic [3:0] wstrb,
      output logic [31:0] val);
      longint unsigned ea, size, off, lim, v;
      kind = 0; addr = 0; wdata = 0; wstrb = 0; val = 0;
      ea = ({32'd0, rs1} + {32'd0, imm}) & 64'hFFFF_FFFF;
      if ((ld && st) || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) begin
         kind = 1;
         return;
      end
      size = 64'd1 << f3[1:0];
      if (ea % size != 0) begin
         kind = 2;
         return;
      end
      off  = ea % 4;
      lim  = 64'd1 << (8 * size);
      addr = 32'(ea - off);
      if (st) begin
         wstrb = 4'(((64'd1 << size) - 1) << off);
         wdata = 32'(({32'd0, rs2} % lim) << (8 * off));
      end else begin
         v = ({32'd0, rdata} >> (8 * off)) % lim;
         if (f3 < 3'd4 && v >= lim / 2) v = v - lim;
         val = 32'(v);
      end
   endfunction

   task automatic do_op(
      input bit ld, input bit st, input logic [2:0] f3,
      input logic [31:0] rs1, input logic [31:0] imm,
      input logic [31:0] rs2, input logic [4:0] rd,
      input int ack_dly, input logic [31:0] rdata,
      output int busy_n, output logic [31:0] got_val);
      int kind, exp_busy;
      bit acked;
      logic [31:0] e_addr, e_wdata, e_val;
      logic [3:0]  e_wstrb;
      model(ld, st, f3, rs1, imm, rs2, rdata,
            kind, e_addr, e_wdata, e_wstrb, e_val);
      busy_n = 0; got_val = 0; acked = 0;
      i_load_en = ld; i_store_en = st; i_funct3 = f3;
      i_rs1_val = rs1; i_imm = imm; i_rs2_val = rs2; i_rd = rd;
      #1;
      if (o_busy) busy_n++;
      if (kind != 0) begin
         chk("err_busy", o_busy, 0);
         @(posedge i_clk); #1; idle_inputs(); i_mem_ack = 1'b1; #1;
         chk("illegal_pulse", o_illegal, kind == 1);
         chk("misaligned_pulse", o_misaligned, kind == 2);
         chk("err_no_req", o_mem_req, 0);
         @(posedge i_clk); #1; i_mem_ack = 1'b0; #1;
         chk("err_pulse_end", {o_illegal, o_misaligned}, 0);
         chk("err_no_req2", {o_mem_req, o_rd_we}, 0);
         exp_busy = 0;
      end else begin
         chk("issue_busy", o_busy, 1);
         @(posedge i_clk); #1; idle_inputs(); #1;
         for (int k = 0; k < TMO; k++) begin
            if (o_busy) busy_n++;
            chk("wait_req", o_mem_req, 1);
            chk("wait_busy", o_busy, 1);
            chk("wait_addr", o_mem_addr, e_addr);
            chk("wait_we", o_mem_we, st);
            chk("wait_wstrb", o_mem_wstrb, e_wstrb);
            if (st) chk("wait_wdata", o_mem_wdata, e_wdata);
            if (k == ack_dly) begin
               i_mem_ack = 1'b1; i_mem_rdata = rdata; acked = 1;
            end
            garbage_inputs();
            @(posedge i_clk); #1;
            i_mem_ack = 1'b0; i_mem_rdata = $urandom; idle_inputs(); #1;
            if (acked) break;
         end
         if (!acked) begin
            chk("tmo_pulse", o_timeout, 1);
            chk("tmo_drop", {o_mem_req, o_rd_we, o_busy}, 0);
            @(posedge i_clk); #1; #1;
            chk("tmo_pulse_end", {o_timeout, o_rd_we}, 0);
            exp_busy = 1 + TMO;
         end else if (ld) begin
            if (o_busy) busy_n++;
            chk("done_we", o_rd_we, rd != 5'd0);
            if (rd != 5'd0) chk("done_rd", o_rd, rd);
            chk("done_val", o_rd_val, e_val);
            chk("done_no_req", o_mem_req, 0);
            got_val = o_rd_val;
            garbage_inputs();
            @(posedge i_clk); #1; idle_inputs(); #1;
            chk("done_once", {o_rd_we, o_busy, o_mem_req}, 0);
            exp_busy = 1 + ack_dly + 1 + 1;
         end else begin
            chk("store_ret", {o_mem_req, o_rd_we, o_busy, o_timeout}, 0);
            exp_busy = 1 + ack_dly + 1;
         end
      end
      chk("busy_cycles", busy_n, exp_busy);
   endtask

   initial begin
      int bn, sel, dly;
      logic [31:0] v, r1, im;
      logic [2:0] f3;
      bit ld, st;

      i_rst = 1'b0;
      i_mem_ack = 1'b0; i_mem_rdata = '0;
      i_load_en = 1'b1; i_store_en = 1'b0; i_funct3 = 3'b010;
      i_rs1_val = 32'h100; i_imm = 0; i_rs2_val = 0; i_rd = 5'd3;
      #2;
      chk("rst_outs_a", {o_busy, o_rd_we, o_rd, o_rd_val,
                         o_mem_req, o_mem_we, o_mem_wstrb}, 0);
      chk("rst_outs_b", {o_mem_addr, o_mem_wdata}, 0);
      chk("rst_pulses", {o_misaligned, o_illegal, o_timeout}, 0);
      @(posedge i_clk); @(posedge i_clk); #1;
      i_rst = 1'b1;

      // LW, ack on the second WAIT cycle
      do_op(1, 0, 3'b010, 32'h1000, 32'd4, 32'd0, 5'd5, 1,
            32'hDEADBEEF, bn, v);
      chk("lw_busy4", bn, 4);
      chk("lw_val", v, 32'hDEADBEEF);

      do_op(1, 0, 3'b000, 32'h1000, 32'd3, 0, 5'd7, 0,
            32'h80112233, bn, v);
      chk("lb_val", v, 32'hFFFFFF80);
      chk("min_latency", bn, 3);
      do_op(1, 0, 3'b100, 32'h1000, 32'd3, 0, 5'd7, 0,
            32'h80112233, bn, v);
      chk("lbu_val", v, 32'h00000080);
      do_op(1, 0, 3'b001, 32'h1000, 32'd2, 0, 5'd8, 2,
            32'h80112233, bn, v);
      chk("lh_val", v, 32'hFFFF8011);

      do_op(0, 1, 3'b001, 32'h2000, 32'd2, 32'h1234ABCD, 5'd9, 1,
            0, bn, v);
      do_op(1, 0, 3'b010, 32'h1000, 32'd2, 0, 5'd5, 0, 0, bn, v);
      do_op(1, 1, 3'b010, 32'h1000, 32'd0, 0, 5'd5, 0, 0, bn, v);
      do_op(0, 1, 3'b110, 32'h1000, 32'd0, 0, 5'd5, 0, 0, bn, v);
      do_op(1, 0, 3'b111, 32'h1000, 32'd0, 0, 5'd5, 0, 0, bn, v);

      // No ack: timeout, then a normal load
      do_op(1, 0, 3'b010, 32'h3000, 32'd0, 0, 5'd4, 100,
            32'h55AA55AA, bn, v);
      chk("tmo_busy", bn, TMO + 1);
      do_op(1, 0, 3'b010, 32'h3000, 32'd8, 0, 5'd4, 0,
            32'h13579BDF, bn, v);
      chk("after_tmo_val", v, 32'h13579BDF);
      // Ack on the last allowed cycle beats the timeout
      do_op(1, 0, 3'b010, 32'h3000, 32'd0, 0, 5'd6, TMO - 1,
            32'h0BADF00D, bn, v);
      do_op(1, 0, 3'b101, 32'h4000, 32'd2, 0, 5'd0, 0,
            32'hFFFF0000, bn, v);

      // Reset during the second WAIT cycle
      i_load_en = 1'b1; i_store_en = 1'b0; i_funct3 = 3'b010;
      i_rs1_val = 32'h1000; i_imm = 0; i_rd = 5'd5;
      @(posedge i_clk); #1; idle_inputs();
      @(posedge i_clk); #1;
      i_rst = 1'b0; #1;
      chk("rst_wait_a", {o_busy, o_rd_we, o_rd, o_rd_val,
                         o_mem_req, o_mem_we, o_mem_wstrb}, 0);
      chk("rst_wait_b", {o_mem_addr, o_mem_wdata}, 0);
      chk("rst_wait_p", {o_misaligned, o_illegal, o_timeout}, 0);
      i_mem_ack = 1'b1; i_mem_rdata = 32'hCAFEF00D;
      @(posedge i_clk); #1;
      i_rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge i_clk); #1; #1;
         chk("rst_no_stale", {o_rd_we, o_mem_req, o_timeout}, 0);
      end
      i_mem_ack = 1'b0;

      for (int n = 0; n < 60; n++) begin
         sel = int'($urandom_range(0, 9));
         ld  = (sel < 5) || (sel == 9);
         st  = (sel >= 5);
         f3  = 3'($urandom);
         r1  = $urandom & ~32'h7;
         im  = 32'($urandom_range(0, 7));
         if ($urandom_range(0, 2) != 0)
            im = im & ~((32'd1 << f3[1:0]) - 32'd1);
         dly = ($urandom_range(0, 7) == 0) ? 20 :
               int'($urandom_range(0, 3));
         do_op(ld, st, f3, r1, im, $urandom, 5'($urandom), dly,
               $urandom, bn, v);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
- REQ-001: Parameter XLEN, default 32, sets the data/address width; legal values are 32 and 64.
- REQ-002: Parameter TIMEOUT, default 16, is the maximum number of WAIT cycles before an access is abandoned; it must be at least 1.
- REQ-003: i_clk  in  1  is the single clock, and all state is rising-edge.
- REQ-004: i_rst  in  1  is the reset: asynchronous and active-low.
- REQ-005: i_load_en  in  1  is a load request this cycle.
- REQ-006: i_store_en  in  1  is a store request this cycle.
- REQ-007: i_funct3  in  3  selects the access size/sign using RISC-V encoding (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU).
- REQ-008: i_rs1_val, i_imm, i_rs2_val  in  XLEN  carry the base, the offset and the store data.
- REQ-009: i_rd  in  5  is the load destination register.
- REQ-010: o_busy  out  1  is the PC/pipeline stall.
- REQ-011: o_rd_we  out  1, o_rd  out  5 and o_rd_val  out  XLEN  form the register-file writeback.
- REQ-012: o_mem_req  out  1, o_mem_we  out  1, o_mem_addr  out  XLEN, o_mem_wdata  out  XLEN and o_mem_wstrb  out  XLEN/8  form the memory request.
- REQ-013: i_mem_ack  in  1 and i_mem_rdata  in  XLEN  form the memory response.
- REQ-014: o_misaligned, o_illegal and o_timeout  out  1 each are single-cycle error pulses.

Function
- REQ-015: The FSM SHALL have three states: IDLE, WAIT and DONE.
- REQ-016: Effective address SHALL be ea = i_rs1_val + i_imm, modulo 2^XLEN.
- REQ-017: o_mem_addr SHALL be ea with its low log2(XLEN/8) bits cleared; the lane offset is those cleared bits.
- REQ-018: An op SHALL be illegal if both enables are high, if funct3 is 111, if funct3 is 110 on a store, or if funct3 is 011 or 110 when XLEN=32.
- REQ-019: An illegal op in IDLE SHALL pulse o_illegal in the next cycle, issue no request and stay in IDLE.
- REQ-020: An op SHALL be misaligned if it is H with ea[0]≠0, W with ea[1:0]≠0, or D with ea[2:0]≠0.
- REQ-021: A misaligned op in IDLE SHALL pulse o_misaligned in the next cycle, issue no request and stay in IDLE.
- REQ-022: A legal, aligned op sampled in IDLE SHALL register addr, wdata, wstrb, rd, funct3 and direction, and move to WAIT at the next edge.
- REQ-023: In WAIT, o_mem_req SHALL be 1, and o_mem_addr, o_mem_we, o_mem_wdata and o_mem_wstrb SHALL stay stable until ack.
- REQ-024: In WAIT with i_mem_ack=1 on a load, the FSM SHALL capture i_mem_rdata and go to DONE.
- REQ-025: In WAIT with i_mem_ack=1 on a store, the FSM SHALL go directly to IDLE.
- REQ-026: Store data SHALL be the low access-size bits of rs2, shifted to the lane offset.
- REQ-027: o_mem_wstrb SHALL have access-size bytes set, starting at the lane offset.
- REQ-028: For loads, o_mem_wstrb SHALL be 0 and o_mem_we SHALL be 0.
- REQ-029: Load data SHALL be the access-size field extracted at the lane offset.
- REQ-030: Load data SHALL be sign-extended for B/H/W and zero-extended for BU/HU/WU; D passes through unchanged.
- REQ-031: In DONE, the unit SHALL drive o_rd_we=1 for exactly one cycle with o_rd and o_rd_val, unless rd=0, in which case o_rd_we stays 0.
- REQ-032: DONE SHALL always return to IDLE at the next edge.
- REQ-033: o_busy SHALL be combinational: 1 when in IDLE with a legal aligned op present, and 1 in WAIT and DONE; 0 otherwise.
- REQ-034: New requests SHALL be ignored outside IDLE.
- REQ-035: Minimum load latency SHALL be: issue at cycle N, o_mem_req at N+1, ack at N+1, o_rd_we at N+2.
- REQ-036: A saturating counter SHALL count WAIT cycles without ack.
- REQ-037: On the TIMEOUT-th such cycle, the unit SHALL pulse o_timeout next cycle, drop the request, return to IDLE and perform no writeback.
- REQ-038: When ack and timeout coincide, ack SHALL win.
- REQ-039: i_mem_ack outside WAIT SHALL be ignored.
- REQ-040: o_mem_addr, o_mem_wdata and o_mem_wstrb SHALL be 0 whenever o_mem_req=0.

Reset
- REQ-041: While i_rst=0, state SHALL be IDLE, the counter and all captured registers SHALL be 0, and every output SHALL be 0, immediately and independent of i_clk.
- REQ-042: Reset asserted during WAIT or DONE SHALL abort the access with no writeback and no error pulse.
- REQ-043: After deassertion, the first edge SHALL sample requests normally.

Verification (XLEN=32)
- REQ-044: LW with rs1=0x1000, imm=4, rd=5, ack after 2 WAIT cycles with rdata=0xDEADBEEF -> o_mem_addr=0x1004, o_busy high for 4 cycles, one o_rd_we pulse with rd=5 and value 0xDEADBEEF.
- REQ-045: LB with ea=0x1003 and rdata=0x80112233 -> o_rd_val=0xFFFFFF80; LBU -> 0x00000080; LH with ea=0x1002 -> 0xFFFF8011.
- REQ-046: SH with ea=0x2002 and rs2=0x1234ABCD -> o_mem_addr=0x2000, wstrb=1100, wdata[31:16]=0xABCD, o_mem_we=1, no o_rd_we.
- REQ-047: LW with ea=0x1002 -> o_misaligned single pulse, no o_mem_req; load_en and store_en together -> o_illegal pulse, no o_mem_req.
- REQ-048: TIMEOUT=8 with no ack -> o_mem_req held 8 cycles, o_timeout pulse, return to IDLE, no writeback; the next LW completes normally.
- REQ-049: i_rst low during the 2nd WAIT cycle -> all outputs 0 in the same cycle; after release, no stale o_rd_we is produced.
